// File: rtl/ntt_mlkem_masked_share_split.sv
// Masking front end for the masked ML-KEM NTT.
// Each unmasked coefficient is reduced mod q and split into two 24-bit
// arithmetic shares. The shares feed the 1x2 masked butterfly pair through a
// 2-stage ready/valid pipeline. A beat counter pulses done_o at the end of
// each polynomial.

// One lane: S1 holds the reduced coefficient and its mask; S2 holds the shares.
module ntt_mlkem_share_lane #(
    parameter int SW = 24,
    parameter int QW = 12,
    parameter int Q  = 3329
) (
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic                 ld1_i,
    input  logic                 ld2_i,
    input  logic [QW-1:0]        coeff_i,
    input  logic [SW-1:0]        rnd_i,
    output logic [1:0][SW-1:0]   share_o
);
    localparam logic [QW-1:0] QV = QW'(Q);

    logic [QW-1:0]       cred_q, cred_d;
    logic [SW-1:0]       rnd_q;
    logic [1:0][SW-1:0]  share_q, share_d;

    // One conditional subtract is enough: the largest input (4095) is below 2q.
    always_comb begin
        cred_d     = (coeff_i >= QV) ? coeff_i - QV : coeff_i;
        share_d[0] = rnd_q;
        share_d[1] = {{(SW-QW){1'b0}}, cred_q} - rnd_q;
    end

    // The unmasked value lives only in cred_q; only shares reach the ports.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cred_q  <= '0;
            rnd_q   <= '0;
            share_q <= '0;
        end else begin
            if (ld1_i) begin
                cred_q <= cred_d;
                rnd_q  <= rnd_i;
            end
            if (ld2_i) share_q <= share_d;
        end
    end

    assign share_o = share_q;
endmodule

module ntt_mlkem_masked_share_split #(
    parameter int MLKEM_SHARE_WIDTH = 24,
    parameter int MLKEM_Q_WIDTH     = 12,
    parameter int MLKEM_Q           = 3329,
    parameter int NUM_BEATS         = 64
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   zeroize,
    input  logic                                   start_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [3:0][MLKEM_Q_WIDTH-1:0]          coeff_i,
    input  logic [3:0][MLKEM_SHARE_WIDTH-1:0]      rnd_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [1:0][MLKEM_SHARE_WIDTH-1:0]      u00_o,
    output logic [1:0][MLKEM_SHARE_WIDTH-1:0]      v00_o,
    output logic [1:0][MLKEM_SHARE_WIDTH-1:0]      u01_o,
    output logic [1:0][MLKEM_SHARE_WIDTH-1:0]      v01_o,
    output logic                                   done_o
);
    localparam int NUM_LANES = 4;
    localparam int SW        = MLKEM_SHARE_WIDTH;
    localparam int CNT_W     = $clog2(NUM_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    // vld_pipe_q[0] is S1, vld_pipe_q[1] is S2 (the output register).
    logic [1:0]       vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             clr, s2_ld, s1_adv, in_hs, out_hs;

    logic [NUM_LANES-1:0][1:0][SW-1:0] share;

    assign clr         = !reset_n || zeroize;
    assign s2_ld       = !vld_pipe_q[1] || out_ready_i;
    assign s1_adv      = s2_ld && vld_pipe_q[0];
    assign in_ready_o  = !start_i && (!vld_pipe_q[0] || s2_ld);
    assign in_hs       = in_valid_i && in_ready_o;
    assign out_hs      = vld_pipe_q[1] && out_ready_i;
    assign out_valid_o = vld_pipe_q[1];
    assign done_o      = done_q;

    // Pipeline valids, beat counter and done pulse; start flushes and wins over done.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        if (start_i) begin
            vld_pipe_d = '0;
            cnt_d      = '0;
        end else begin
            if (s2_ld) vld_pipe_d[1] = vld_pipe_q[0];
            if (in_hs)      vld_pipe_d[0] = 1'b1;
            else if (s2_ld) vld_pipe_d[0] = 1'b0;
            if (out_hs) begin
                if (cnt_q == LAST_BEAT) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Control state; zeroize clears exactly like reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_pipe_q <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ntt_mlkem_share_lane #(
            .SW (SW),
            .QW (MLKEM_Q_WIDTH),
            .Q  (MLKEM_Q)
        ) u_lane (
            .clk     (clk),
            .clr_i   (clr),
            .ld1_i   (in_hs),
            .ld2_i   (s1_adv),
            .coeff_i (coeff_i[l]),
            .rnd_i   (rnd_i[l]),
            .share_o (share[l])
        );
    end

    assign u00_o = share[0];
    assign v00_o = share[1];
    assign u01_o = share[2];
    assign v01_o = share[3];
endmodule

// File: tb/tb_ntt_mlkem_masked_share_split.sv
// Bench for ntt_mlkem_masked_share_split: scoreboard of expected shares,
// done-pulse model and stall-stability checks, driven by scenario tasks.
module tb_ntt_mlkem_masked_share_split;
    typedef logic [3:0][11:0]      coeff_t;
    typedef logic [3:0][23:0]      rnd_t;
    typedef logic [3:0][1:0][23:0] shares_t;

    logic clk = 1'b0;
    logic reset_n, zeroize, start_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, done_o;
    coeff_t coeff_i;
    rnd_t   rnd_i;
    logic [1:0][23:0] u00_o, v00_o, u01_o, v01_o;

    int checks = 0;
    int errors = 0;
    int n_out = 0, n_done = 0, n_inblock = 0;
    shares_t sb_q[$];

    always #5 clk = ~clk;

    ntt_mlkem_masked_share_split dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .coeff_i(coeff_i), .rnd_i(rnd_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .u00_o(u00_o), .v00_o(v00_o), .u01_o(u01_o), .v01_o(v01_o), .done_o(done_o)
    );

    function automatic shares_t model(coeff_t c, rnd_t r);
        shares_t s;
        for (int l = 0; l < 4; l++) begin
            logic [11:0] cr;
            cr = (c[l] >= 12'd3329) ? c[l] - 12'd3329 : c[l];
            s[l][0] = r[l];
            s[l][1] = {12'd0, cr} - r[l];
        end
        return s;
    endfunction

    function automatic coeff_t rand_coeff();
        coeff_t c;
        for (int l = 0; l < 4; l++) c[l] = 12'($urandom);
        return c;
    endfunction

    function automatic rnd_t rand_rnd();
        rnd_t r;
        for (int l = 0; l < 4; l++) r[l] = 24'($urandom);
        return r;
    endfunction

    // Scoreboard, done model and stall stability, sampled mid-cycle.
    task automatic monitor();
        int      bcnt = 0;
        logic    exp_done = 1'b0;
        logic    stall_prev = 1'b0;
        shares_t held = '0;
        shares_t obs, exp;
        forever begin
            @(negedge clk);
            obs = {v01_o, u01_o, v00_o, u00_o};
            checks++;
            if (done_o !== exp_done) begin
                errors++;
                $display("FAIL done_pulse t=%0t got=%b want=%b", $time, done_o, exp_done);
            end
            if (done_o === 1'b1) n_done++;
            if (stall_prev) begin
                checks++;
                if (out_valid_o !== 1'b1 || obs !== held) begin
                    errors++;
                    $display("FAIL stall_stable t=%0t valid=%b got=%h want=%h", $time, out_valid_o, obs, held);
                end
            end
            if (in_valid_i && !in_ready_o) n_inblock++;
            if (!reset_n || zeroize || start_i) begin
                sb_q.delete();
                bcnt = 0;
                exp_done = 1'b0;
                stall_prev = 1'b0;
            end else begin
                exp_done = 1'b0;
                if (out_valid_o && out_ready_i) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output t=%0t got=%h", $time, obs);
                    end else begin
                        exp = sb_q.pop_front();
                        if (obs !== exp) begin
                            errors++;
                            $display("FAIL shares t=%0t got=%h want=%h", $time, obs, exp);
                        end
                    end
                    for (int l = 0; l < 4; l++) begin
                        logic [23:0] sum;
                        sum = obs[l][0] + obs[l][1];
                        checks++;
                        if (sum >= 24'd3329) begin
                            errors++;
                            $display("FAIL share_sum lane%0d got=%0d want=<3329", l, sum);
                        end
                    end
                    n_out++;
                    if (bcnt == 63) begin bcnt = 0; exp_done = 1'b1; end
                    else bcnt++;
                end
                if (in_valid_i && in_ready_o) sb_q.push_back(model(coeff_i, rnd_i));
                stall_prev = out_valid_o && !out_ready_i;
                held = obs;
            end
        end
    endtask

    task automatic drive_beat(input coeff_t c, input rnd_t r);
        logic ok = 1'b0;
        coeff_i = c; rnd_i = r; in_valid_i = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready_o) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout t=%0t got=in_ready_low want=accept", $time);
        end
    endtask

    task automatic drain();
        logic ok = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid_o) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout got=%0d pending want=0", sb_q.size());
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic check_cleared(input string name);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || done_o !== 1'b0 ||
            {u00_o, v00_o, u01_o, v01_o} !== '0) begin
            errors++;
            $display("FAIL %s got valid=%b ready=%b done=%b data=%h want=0/1/0/0", name,
                     out_valid_o, in_ready_o, done_o, {u00_o, v00_o, u01_o, v01_o});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check_cleared("reset_state");
    endtask

    task automatic test_single();
        out_ready_i = 1'b1;
        drive_beat({12'd1664, 12'd3328, 12'd1, 12'd0},
                   {24'h000800, 24'hFFFFFF, 24'd5, 24'd0});
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("FAIL latency_early got=%b want=0", out_valid_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || u00_o !== {24'h0, 24'h0} ||
            v00_o !== {24'hFFFFFC, 24'h000005} || u01_o !== {24'h000D01, 24'hFFFFFF} ||
            v01_o !== {24'hFFFE80, 24'h000800}) begin
            errors++;
            $display("FAIL single_beat got v=%b %h %h %h %h", out_valid_o, u00_o, v00_o, u01_o, v01_o);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_reduction();
        logic ok = 1'b0;
        out_ready_i = 1'b1;
        drive_beat({12'd3328, 12'd3330, 12'd4095, 12'd3329}, '0);
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (out_valid_o) begin
                ok = 1'b1;
                checks++;
                if (u00_o !== {24'd0, 24'd0} || v00_o !== {24'd766, 24'd0} ||
                    u01_o !== {24'd1, 24'd0} || v01_o !== {24'd3328, 24'd0}) begin
                    errors++;
                    $display("FAIL reduction got %h %h %h %h want share1=0,766,1,3328", u00_o, v00_o, u01_o, v01_o);
                end
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++; $display("FAIL reduction_timeout got=no_output want=output");
        end
        drain();
    endtask

    task automatic test_backpressure();
        int o0 = n_out, b0 = n_inblock;
        fork
            begin
                for (int i = 0; i < 8; i++) drive_beat(rand_coeff(), rand_rnd());
            end
            begin
                for (int cyc = 0; cyc < 20; cyc++) begin
                    out_ready_i = !(cyc >= 3 && cyc <= 6);
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        checks++;
        if (n_out - o0 != 8) begin
            errors++; $display("FAIL bp_count got=%0d want=8", n_out - o0);
        end
        checks++;
        if (n_inblock == b0) begin
            errors++; $display("FAIL bp_in_ready got=never_low want=low_while_full");
        end
    endtask

    task automatic test_full_poly();
        int o0, d0;
        out_ready_i = 1'b1;
        pulse_start();
        o0 = n_out; d0 = n_done;
        for (int i = 0; i < 64; i++) drive_beat(rand_coeff(), rand_rnd());
        drain();
        checks++;
        if (n_out - o0 != 64 || n_done - d0 != 1) begin
            errors++; $display("FAIL full_poly got out=%0d done=%0d want=64/1", n_out - o0, n_done - d0);
        end
    endtask

    task automatic test_start_flush();
        int o0, d0;
        out_ready_i = 1'b1;
        pulse_start();
        for (int i = 0; i < 10; i++) drive_beat(rand_coeff(), rand_rnd());
        drain();
        out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) drive_beat(rand_coeff(), rand_rnd());
        pulse_start();
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_valid got=%b want=0", out_valid_o);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        o0 = n_out; d0 = n_done;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n_out != o0) begin
            errors++; $display("FAIL flush_dropped got=%0d want=0", n_out - o0);
        end
        for (int i = 0; i < 64; i++) drive_beat(rand_coeff(), rand_rnd());
        drain();
        checks++;
        if (n_out - o0 != 64 || n_done - d0 != 1) begin
            errors++; $display("FAIL flush_next_poly got out=%0d done=%0d want=64/1", n_out - o0, n_done - d0);
        end
    endtask

    task automatic test_start_on_last();
        int d0;
        out_ready_i = 1'b1;
        pulse_start();
        for (int i = 0; i < 63; i++) drive_beat(rand_coeff(), rand_rnd());
        drain();
        out_ready_i = 1'b0;
        drive_beat(rand_coeff(), rand_rnd());
        repeat (3) @(posedge clk);
        #1;
        d0 = n_done;
        out_ready_i = 1'b1;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_done != d0) begin
            errors++; $display("FAIL start_on_last got=%0d done want=0", n_done - d0);
        end
    endtask

    task automatic test_zeroize_reset();
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) drive_beat(rand_coeff(), rand_rnd());
        drain();
        out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) drive_beat(rand_coeff(), rand_rnd());
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        check_cleared("zeroize_state");
        for (int i = 0; i < 2; i++) drive_beat(rand_coeff(), rand_rnd());
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_cleared("reset_midstream");
    endtask

    task automatic test_random_stream();
        int   o0 = n_out;
        logic fin = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    drive_beat(rand_coeff(), rand_rnd());
                    if ($urandom_range(7) == 0) begin @(posedge clk); #1; end
                end
                fin = 1'b1;
            end
            begin
                while (!fin) begin
                    out_ready_i = ($urandom_range(3) != 0);
                    @(posedge clk); #1;
                end
                out_ready_i = 1'b1;
            end
        join
        drain();
        checks++;
        if (n_out - o0 != 10000) begin
            errors++; $display("FAIL random_count got=%0d want=10000", n_out - o0);
        end
    endtask

    initial begin
        reset_n = 1'b0; zeroize = 1'b0; start_i = 1'b0; in_valid_i = 1'b0;
        out_ready_i = 1'b0; coeff_i = '0; rnd_i = '0;
        fork monitor(); join_none
        test_reset();
        test_single();
        test_reduction();
        test_backpressure();
        test_full_poly();
        test_start_flush();
        test_start_on_last();
        test_zeroize_reset();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ntt_mlkem_masked_share_split.md
Name: ntt_mlkem_masked_share_split

Overview:
Front-end masking stage for the masked ML-KEM NTT datapath. It is the inverse of the INTT share-combine/div2 output stage.
- Accepts 4 unmasked 12-bit coefficients per beat and reduces each into [0, MLKEM_Q).
- Splits each coefficient into two 24-bit arithmetic shares (sum mod 2^24 equals the coefficient), using fresh randomness.
- Delivers the shares as the u00/v00/u01/v01 operands of the 1x2 masked butterfly pair, through a 2-stage ready/valid pipeline.
- Counts beats per polynomial and pulses done at the end.

Parameters:
MLKEM_SHARE_WIDTH, 24, width of one arithmetic share
MLKEM_Q_WIDTH, 12, width of an unmasked coefficient
MLKEM_Q, 3329, modulus
NUM_BEATS, 64, beats per polynomial (256 coeffs / 4 lanes)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
zeroize  in  1  synchronous clear of all state and data
start_i  in  1  begin new polynomial; flushes pipeline, clears beat counter
in_valid_i  in  1  coeff_i/rnd_i valid
in_ready_o  out  1  block accepts a beat
coeff_i  in  4x12  unmasked coefficients, lane 0..3
rnd_i  in  4x24  fresh random mask per lane
out_valid_o  out  1  outputs valid
out_ready_i  in  1  downstream accepts
u00_o, v00_o, u01_o, v01_o  out  2x24 each  share pairs [1:0]; lanes 0,1,2,3 respectively
done_o  out  1  one-cycle pulse after last beat of polynomial

Behaviour:
Clock and reset:
- One clock, clk. Reset is reset_n: synchronous, active-low.
- Every register resets to 0: out_valid_o=0, all share outputs 0, done_o=0, beat counter 0, internal valids 0. in_ready_o is therefore 1 after reset.
- zeroize (sampled high at a clock edge) has the same effect as reset, including all data registers. zeroize takes priority over start_i and any handshake in that cycle.

Pipeline:
- S1 captures coeff_i and rnd_i on an input handshake (in_valid_i & in_ready_o). rnd_i is sampled in the same cycle as its coefficient and never reused.
- S1 reduction: c_red = (c >= MLKEM_Q) ? c - MLKEM_Q : c. A single subtraction suffices because 4095 < 2*MLKEM_Q.
- S2 (output register) share computation: share[0] = r; share[1] = (zero-extend(c_red) - r) mod 2^24.
- Invariant on every valid output: share[0]+share[1] mod 2^MLKEM_SHARE_WIDTH equals c_red, and c_red < MLKEM_Q.
- Latency: an accepted beat appears on out_valid_o 2 cycles later if there is no backpressure.
- Stall rules:
  - S2 loads when !out_valid_o or out_ready_i.
  - S1 advances into S2 under the same condition.
  - in_ready_o = !s1_valid | (S2 load condition). The result is full throughput of 1 beat/cycle.
- Output data and out_valid_o hold stable while out_valid_o=1 and out_ready_i=0.
- The unmasked c_red must never appear on an output port. It exists only in the S1 register.

Beat counter and done:
- 6-bit counter increments on each output handshake (out_valid_o & out_ready_i).
- On the handshake for beat NUM_BEATS-1: counter wraps to 0 and done_o=1 in the next cycle, for exactly one cycle.
- Beats offered after the wrap are processed normally as a new polynomial.

start_i:
- In the start cycle: clear S1/S2 valids, dropping in-flight beats; clear the counter; in_ready_o=0, so no beat is accepted.
- out_valid_o is 0 from the next cycle. Data registers are not required to clear.
- start_i coincident with the last output handshake: start wins and done_o is not pulsed.

Simultaneous input and output handshakes in the same cycle are legal and required. With S2 full and out_ready_i=1, a new beat enters S1 while S1 moves to S2.

Test Plan:
1. Single beat, coeff={0,1,3328,1664}, rnd={0,5,0xFFFFFF,0x000800}, out_ready_i=1 -> out_valid_o 2 cycles after accept. u00={0,0}; v00={5,0xFFFFFC}; u01={0xFFFFFF,0x000D01}; v01={0x000800,0xFFFE80}.
2. Reduction: coeff={3329,4095,3330,3328}, rnd=0 -> share[1]={0,766,1,3328}; share sum mod 2^24 always < 3329.
3. Backpressure: stream 8 beats, out_ready_i low cycles 3-6 -> in_ready_o drops once S1 and S2 are full. No beat is lost or duplicated, outputs are stable while stalled, and output order is preserved.
4. Full polynomial: start_i, then 64 back-to-back beats with out_ready_i=1 -> 64 output handshakes, done_o high exactly one cycle after the 64th, counter back to 0.
5. start_i after beat 10 with 2 beats in flight -> in-flight beats never appear; out_valid_o=0 next cycle; the next polynomial's done_o fires after 64 more beats.
6. zeroize, then reset_n=0, each mid-stream -> next cycle all outputs 0, out_valid_o=0, in_ready_o=1, counter 0. A random sum-invariant check over 10k beats passes.
